// File: rtl/button_conditioner_if.sv
// Raw push-button / slide-switch inputs and their conditioned outputs.
// master drives the raw inputs; slave is the conditioner itself.
interface button_conditioner_if;
  logic       button_raw;
  logic       sel_raw;
  logic       button;
  logic       press;
  logic       long_press;
  logic       sel;
  logic [7:0] press_count;

  modport master (
    output button_raw,
    output sel_raw,
    input  button,
    input  press,
    input  long_press,
    input  sel,
    input  press_count
  );

  modport slave (
    input  button_raw,
    input  sel_raw,
    output button,
    output press,
    output long_press,
    output sel,
    output press_count
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a push-button and a select switch.
// Also derives press / long-press pulses and a saturating press counter.
module button_conditioner #(
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned LONG_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int unsigned DB_W   = 8;
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_e;

  logic              btn_s1_q, btn_s2_q;
  logic              sel_s1_q, sel_s2_q;
  logic              btn_level_q, btn_level_d;
  logic              sel_level_q, sel_level_d;
  logic [DB_W-1:0]   btn_db_q, btn_db_d;
  logic [DB_W-1:0]   sel_db_q, sel_db_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Button debouncer: level follows the sample only after DB_CYCLES straight mismatches
  always_comb begin
    btn_level_d = btn_level_q;
    btn_db_d    = '0;
    if (btn_s2_q != btn_level_q) begin
      if (btn_db_q == DB_LAST) begin
        btn_level_d = btn_s2_q;
      end else begin
        btn_db_d = btn_db_q + DB_W'(1);
      end
    end
  end

  // Select debouncer, identical to the button one
  always_comb begin
    sel_level_d = sel_level_q;
    sel_db_d    = '0;
    if (sel_s2_q != sel_level_q) begin
      if (sel_db_q == DB_LAST) begin
        sel_level_d = sel_s2_q;
      end else begin
        sel_db_d = sel_db_q + DB_W'(1);
      end
    end
  end

  // Press FSM tracks the next debounced level so pulses line up with the button edge
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (btn_level_d) begin
          state_d = HELD;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (!btn_level_d) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LONG: begin
        if (!btn_level_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (press_d && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      sel_s1_q    <= 1'b0;
      sel_s2_q    <= 1'b0;
      btn_level_q <= 1'b0;
      sel_level_q <= 1'b0;
      btn_db_q    <= '0;
      sel_db_q    <= '0;
      state_q     <= IDLE;
      hold_q      <= '0;
      press_q     <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      btn_s1_q    <= bus.button_raw;
      btn_s2_q    <= btn_s1_q;
      sel_s1_q    <= bus.sel_raw;
      sel_s2_q    <= sel_s1_q;
      btn_level_q <= btn_level_d;
      sel_level_q <= sel_level_d;
      btn_db_q    <= btn_db_d;
      sel_db_q    <= sel_db_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      press_q     <= press_d;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  assign bus.button      = btn_level_q;
  assign bus.sel         = sel_level_q;
  assign bus.press       = press_q;
  assign bus.long_press  = long_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DB_CYCLES=4, LONG_CYCLES=16).
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   press_seen = 0;
  int   long_seen  = 0;
  int   both_seen  = 0;
  int   snap_press;
  int   snap_long;

  button_conditioner_if bif ();

  button_conditioner #(
    .DB_CYCLES  (4),
    .LONG_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (bif.press) press_seen++;
    if (bif.long_press) long_seen++;
    if (bif.press && bif.long_press) both_seen++;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tap();
    bif.button_raw = 1'b1;
    cycles(6);
    bif.button_raw = 1'b0;
    cycles(6);
  endtask

  initial begin
    rst = 1'b1;
    bif.button_raw = 1'b0;
    bif.sel_raw    = 1'b0;
    cycles(3);
    check("rst_button", 32'(bif.button), 0);
    check("rst_press", 32'(bif.press), 0);
    check("rst_long", 32'(bif.long_press), 0);
    check("rst_sel", 32'(bif.sel), 0);
    check("rst_count", 32'(bif.press_count), 0);
    rst = 1'b0;

    // clean press: rises after edge 5, released after 10 cycles
    bif.button_raw = 1'b1;
    cycles(5);
    check("clean_before_e5", 32'(bif.button), 0);
    cycles(1);
    check("clean_button_e5", 32'(bif.button), 1);
    check("clean_press_e5", 32'(bif.press), 1);
    check("clean_count", 32'(bif.press_count), 1);
    cycles(1);
    check("clean_press_one_cycle", 32'(bif.press), 0);
    check("clean_button_held", 32'(bif.button), 1);
    cycles(4);
    bif.button_raw = 1'b0;
    cycles(5);
    check("clean_fall_before", 32'(bif.button), 1);
    cycles(1);
    check("clean_fall_after", 32'(bif.button), 0);
    check("clean_no_long", 32'(long_seen), 0);

    // bounce: 1,2,3-cycle highs with 1-cycle lows, then steady high
    snap_press = press_seen;
    bif.button_raw = 1'b1; cycles(1);
    bif.button_raw = 1'b0; cycles(1);
    bif.button_raw = 1'b1; cycles(2);
    bif.button_raw = 1'b0; cycles(1);
    bif.button_raw = 1'b1; cycles(3);
    bif.button_raw = 1'b0; cycles(1);
    check("bounce_no_change", 32'(bif.button), 0);
    bif.button_raw = 1'b1;
    cycles(5);
    check("bounce_before_e5", 32'(bif.button), 0);
    cycles(1);
    check("bounce_button_e5", 32'(bif.button), 1);
    check("bounce_press_e5", 32'(bif.press), 1);
    cycles(1);
    check("bounce_one_press", 32'(press_seen - snap_press), 1);

    // long press continues from the bounce press (press after e5, long after e21)
    snap_long = long_seen;
    cycles(14);
    check("long_before", 32'(bif.long_press), 0);
    cycles(1);
    check("long_pulse", 32'(bif.long_press), 1);
    check("long_no_press", 32'(bif.press), 0);
    cycles(1);
    check("long_one_cycle", 32'(bif.long_press), 0);
    cycles(8);
    check("long_single", 32'(long_seen - snap_long), 1);
    bif.button_raw = 1'b0;
    cycles(6);
    check("long_released", 32'(bif.button), 0);

    // release so the debounced fall lands on hold counter = 15
    snap_long = long_seen;
    bif.button_raw = 1'b1;
    cycles(6);
    check("thr_press_from_idle", 32'(bif.press), 1);
    cycles(10);
    bif.button_raw = 1'b0;
    cycles(5);
    check("thr_still_high", 32'(bif.button), 1);
    cycles(1);
    check("thr_fell", 32'(bif.button), 0);
    check("thr_no_long_now", 32'(bif.long_press), 0);
    cycles(3);
    check("thr_no_long", 32'(long_seen - snap_long), 0);
    bif.button_raw = 1'b1;
    cycles(6);
    check("thr_repress", 32'(bif.press), 1);
    bif.button_raw = 1'b0;
    cycles(6);
    check("count_after_4", 32'(bif.press_count), 4);

    // sel: 2-cycle glitch ignored, steady change followed after edge 5
    snap_press = press_seen;
    bif.sel_raw = 1'b1; cycles(2);
    bif.sel_raw = 1'b0; cycles(6);
    check("sel_glitch", 32'(bif.sel), 0);
    bif.sel_raw = 1'b1;
    cycles(5);
    check("sel_before_e5", 32'(bif.sel), 0);
    cycles(1);
    check("sel_after_e5", 32'(bif.sel), 1);
    check("sel_button_idle", 32'(bif.button), 0);
    check("sel_no_press", 32'(press_seen - snap_press), 0);
    check("sel_count", 32'(bif.press_count), 4);

    // saturation: 260 presses total
    snap_press = press_seen;
    for (int i = 0; i < 251; i++) tap();
    check("sat_reach", 32'(bif.press_count), 255);
    for (int i = 0; i < 5; i++) tap();
    check("sat_hold", 32'(bif.press_count), 255);
    check("sat_pulses", 32'(press_seen - snap_press), 256);

    // reset mid-hold with raw still high
    bif.button_raw = 1'b1;
    cycles(10);
    check("mid_hold_button", 32'(bif.button), 1);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_button", 32'(bif.button), 0);
    check("mid_rst_press", 32'(bif.press), 0);
    check("mid_rst_long", 32'(bif.long_press), 0);
    check("mid_rst_sel", 32'(bif.sel), 0);
    check("mid_rst_count", 32'(bif.press_count), 0);
    rst = 1'b0;
    cycles(5);
    check("post_rst_before", 32'(bif.button), 0);
    check("post_rst_sel_dice", 32'(bif.sel), 0);
    cycles(1);
    check("post_rst_button", 32'(bif.button), 1);
    check("post_rst_press", 32'(bif.press), 1);
    check("post_rst_count", 32'(bif.press_count), 1);
    check("post_rst_sel", 32'(bif.sel), 1);
    cycles(2);
    check("never_both", 32'(both_seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4: consecutive stable synchronized cycles required to accept a level change (legal range 2..255).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 16: cycles the debounced button must stay high before a long press fires (legal range 2..65535, > DB_CYCLES).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port button_raw, input, 1 bit: asynchronous, bouncy push-button.
REQ-006 The block SHALL have port sel_raw, input, 1 bit: asynchronous, bouncy slide switch (0 = dice, 1 = traffic lights).
REQ-007 The block SHALL have port button, output, 1 bit: debounced button level, fed to the downstream dice/lights multiplexer.
REQ-008 The block SHALL have port press, output, 1 bit: one-cycle pulse on each accepted press.
REQ-009 The block SHALL have port long_press, output, 1 bit: one-cycle pulse when a press has been held LONG_CYCLES cycles.
REQ-010 The block SHALL have port sel, output, 1 bit: debounced select level, fed to the downstream multiplexer.
REQ-011 The block SHALL have port press_count, output, 8 bits: number of accepted presses since reset, saturating.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer; no logic SHALL use button_raw or sel_raw directly.
REQ-013 Each debouncer SHALL keep a mismatch counter that clears whenever the synchronized sample equals the current debounced level.
REQ-014 The counter SHALL increment on each cycle where the sample differs from the level.
REQ-015 On the cycle where the sample differs and the counter equals DB_CYCLES-1, the debouncer SHALL copy the sample into the level and clear the counter.
REQ-016 Latency: with the first edge that samples a new raw value counted as edge 0 and the raw value held, the debounced output SHALL change after edge DB_CYCLES+1 (edge 5 at default).
REQ-017 A raw pulse or glitch that does not reach DB_CYCLES consecutive synchronized mismatches SHALL leave the level unchanged and SHALL produce no press.
REQ-018 The button path FSM SHALL have three states: IDLE (level 0), HELD (level 1, hold counter running), LONG (level 1, long press already issued).
REQ-019 IDLE -> HELD SHALL occur when the debounced level rises; press SHALL be high in the first cycle button is high, for exactly one cycle; the hold counter SHALL load 0.
REQ-020 In HELD the hold counter SHALL increment each cycle.
REQ-021 When the hold counter equals LONG_CYCLES-1, the FSM SHALL go HELD -> LONG and long_press SHALL be high for exactly that one following cycle, LONG_CYCLES cycles after press.
REQ-022 A debounced fall in HELD or LONG SHALL return the FSM to IDLE with no pulse.
REQ-023 A fall on the same edge the long-press condition is met SHALL take priority: the FSM goes to IDLE and no long_press is issued.
REQ-024 Holding the button beyond LONG_CYCLES SHALL produce no further pulses until release and re-press.
REQ-025 press_count SHALL increment by 1 on every press pulse and SHALL saturate at 255 with no wrap.
REQ-026 The sel path SHALL use the identical debouncer with no FSM; sel changes SHALL NOT affect the button path.
REQ-027 press and long_press SHALL never be high in the same cycle.

Reset
REQ-028 While rst is high at a clock edge, the synchronizers, counters, button, sel, press, long_press and press_count SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-029 Reset SHALL take priority over all other activity, including a press or long press in progress.
REQ-030 If button_raw is held high through reset release, the block SHALL re-debounce from level 0 and issue one press DB_CYCLES+1 edges after the first post-reset sampling edge.
REQ-031 After reset release, sel SHALL be 0 (dice) until sel_raw has been debounced high.

Verification
REQ-032 Scenario clean press: DB_CYCLES=4, button_raw raised and held 10 cycles -> button rises after edge 5; press high for 1 cycle; press_count = 1.
REQ-033 Scenario bounce: pulses of 1, 2 and 3 cycles high separated by 1-cycle lows, then steady high -> exactly one press, occurring 5 edges after the start of the steady high.
REQ-034 Scenario long press: held 30 cycles, LONG_CYCLES=16 -> long_press 1 cycle, 16 cycles after press; no second pulse; release returns FSM to IDLE.
REQ-035 Scenario release at the threshold: debounced fall coincides with hold counter = 15 -> no long_press; FSM in IDLE.
REQ-036 Scenario saturation and reset: 260 clean presses -> press_count = 255; rst pulsed mid-hold -> all outputs 0 next edge; raw input still high -> new press after edge 5.
REQ-037 Scenario sel: sel_raw toggled with a 2-cycle glitch, then a steady change -> sel ignores the glitch and follows the steady change after edge 5; button and press are unaffected.
